mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs: decodes the instruction held in M and performs the load or store over a req/ack data-memory bus.
- Drives stall_M back to the pipeline. stall_M low is the EN of the EX/MEM register and of all earlier stage registers.
- Produces a byte-lane-correct, size-extended load result for the MEM/WB register.
- Sits between the EX/MEM register and the data memory, so memories with variable latency are tolerated.

Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without mem_ack before the access is aborted with bus_err.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- Instr_M  in  32  instruction held in the EX/MEM register.
- pc_M  in  32  PC of that instruction; used only by the optional exception path.
- ALUout_M  in  32  effective address.
- RD2_M  in  32  store data, taken unshifted from rt.
- stall_M  out  1  hold request to the pipeline.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address: {ALUout_M[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data; valid when mem_ack=1.
- mem_ack  in  1  single-cycle acknowledge.
- ld_data  out  32  extended load result.
- bus_err  out  1  one-cycle pulse on timeout.
- addr_exc  out  2  misaligned-address exception code: 01 = load, 10 = store, 00 = none.
- exc_pc  out  32  PC of the faulting instruction.

Behaviour:
- Decode on Instr_M[31:26]:
  - Loads: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
  - Stores: sw 101011, sb 101000, sh 101001.
  - Any other opcode is a non-memory instruction.
- Reset values: state IDLE; all outputs 0; ld_data 0; wait counter 0.
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE, memory op present: stall_M=1 combinationally. Next state BUSY; mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered from the decode.
  - IDLE, non-memory op: stall_M=0; stay in IDLE.
  - BUSY: stall_M=1; mem_req and all bus outputs held stable; counter increments each cycle.
    - On mem_ack=1: capture the extended mem_rdata into ld_data (stores leave ld_data unchanged). Drop mem_req and go to DONE.
    - If the counter reaches TIMEOUT_CYCLES without ack: drop mem_req, pulse bus_err=1 for that edge's following cycle, set ld_data=0, go to DONE.
  - DONE: stall_M=0, so the pipeline advances on this edge and MEM/WB samples ld_data. Counter cleared; next state IDLE unconditionally.
- Back-to-back memory ops: the new instruction enters M on the DONE edge. It is detected in IDLE the following cycle, so there is no lost or duplicated access.
- Minimum occupancy of M by a memory op is 3 cycles (IDLE, BUSY with ack, DONE). A non-memory op occupies M for 1 cycle.
- An ack arriving outside BUSY is ignored.
- Byte lanes, with a = ALUout_M[1:0]:
  - sb: mem_be = 1<<a; mem_wdata = {4{RD2_M[7:0]}}.
  - sh: mem_be = a[1] ? 1100 : 0011; mem_wdata = {2{RD2_M[15:0]}}.
  - sw: mem_be = 1111; mem_wdata = RD2_M.
  - Loads drive the same mem_be as the equivalent-size store, with mem_we=0.
- Load extension:
  - lb/lbu select byte a and extend it (sign-extend for lb, zero-extend for lbu).
  - lh/lhu select halfword a[1] and extend it the same way.
  - lw passes the word through unchanged.
- Reset asserted mid-access: immediate return to IDLE, mem_req=0 asynchronously. The bus must tolerate the abandoned request.

Optional Feature:
- Macro: ALIGN_EXC_EN.
- Defined:
  - lw/sw with a != 00, or lh/lhu/sh with a[0]=1, issues no bus request.
  - IDLE goes straight to DONE (2 cycles) and asserts addr_exc (01 load, 10 store) with exc_pc=pc_M during the DONE cycle.
  - ld_data is forced to 0.
- Undefined: addr_exc and exc_pc are tied to 0; misaligned low address bits are ignored (word ignores a, halfword ignores a[0]).

Test Plan:
- sw: ALUout_M=0x100, RD2_M=0xDEADBEEF, ack in the first BUSY cycle -> mem_req=1, we=1, addr=0x100, be=1111 for 1 cycle; stall_M high exactly 2 cycles, low in the 3rd.
- lb: ALUout_M=0x203, mem_rdata=0x80FF1234, ack after 4 BUSY cycles -> be=1000, ld_data=0xFFFFFF80, stall_M high 6 cycles. The same access with lbu -> ld_data=0x00000080.
- sh: ALUout_M=0x12, RD2_M=0x0000ABCD -> be=1100, wdata=0xABCDABCD. Follow with lhu at 0x12, rdata=0xABCD0000 -> ld_data=0x0000ABCD. Back-to-back, with no gap beyond the IDLE detect cycle.
- No ack, TIMEOUT_CYCLES=4 -> mem_req drops after 4 BUSY cycles, bus_err pulses 1 cycle, ld_data=0, pipeline resumes.
- Reset driven 0 in the 2nd BUSY cycle -> mem_req, stall_M and ld_data go to 0 immediately without a clock edge. After release, the same instruction is re-issued from IDLE.
- With ALIGN_EXC_EN, lw at 0x101 -> no mem_req, addr_exc=01, exc_pc=pc_M, stall_M high 1 cycle. Without the macro -> normal access at addr 0x100.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store sequencer on a req/ack data bus.
// Decodes the instruction held in M, issues one registered bus request,
// holds the pipeline via stall_M until the access completes (or times out),
// and returns a byte-lane-selected, size-extended load result.
// Optional build macro ALIGN_EXC_EN: misaligned word/halfword accesses raise
// addr_exc instead of touching the bus.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M,
    input  logic [31:0] pc_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] RD2_M,
    output logic        stall_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ld_data,
    output logic        bus_err,
    output logic [1:0]  addr_exc,
    output logic [31:0] exc_pc
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [5:0]  op;
    logic [1:0]  lane;
    logic        is_load, is_store, is_mem, sgn;
    size_t       size;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;

    // access attributes latched at issue, used to extend the returned word
    logic        ld_is_load, ld_sgn;
    size_t       ld_size;
    logic [1:0]  ld_lane;

    logic        unused_bits;

    assign op     = Instr_M[31:26];
    assign lane   = ALUout_M[1:0];
    assign is_mem = is_load | is_store;

    // Opcode decode plus byte-enable / store-data lane placement
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        sgn       = 1'b0;
        size      = SZ_W;
        case (op)
            6'b100011: begin is_load  = 1'b1; size = SZ_W;              end
            6'b100000: begin is_load  = 1'b1; size = SZ_B; sgn = 1'b1; end
            6'b100100: begin is_load  = 1'b1; size = SZ_B;              end
            6'b100001: begin is_load  = 1'b1; size = SZ_H; sgn = 1'b1; end
            6'b100101: begin is_load  = 1'b1; size = SZ_H;              end
            6'b101011: begin is_store = 1'b1; size = SZ_W;              end
            6'b101000: begin is_store = 1'b1; size = SZ_B;              end
            6'b101001: begin is_store = 1'b1; size = SZ_H;              end
            default:   ;
        endcase
        be_dec    = 4'b1111;
        wdata_dec = RD2_M;
        case (size)
            SZ_B: begin
                be_dec    = 4'b0001 << lane;
                wdata_dec = {4{RD2_M[7:0]}};
            end
            SZ_H: begin
                be_dec    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{RD2_M[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef ALIGN_EXC_EN
    logic misalign;
    assign misalign = (size == SZ_W && lane != 2'b00) ||
                      (size == SZ_H && lane[0]);
    assign unused_bits = ^Instr_M[25:0];
`else
    assign addr_exc    = 2'b00;
    assign exc_pc      = 32'h0;
    assign unused_bits = ^{Instr_M[25:0], pc_M};
`endif

    // Select the addressed byte/halfword of a returned word and extend it
    function automatic logic [31:0] extend(input logic [31:0] w, input size_t sz,
                                           input logic s, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_B:    extend = {{24{s & b[7]}}, b};
            SZ_H:    extend = {{16{s & h[15]}}, h};
            default: extend = w;
        endcase
    endfunction

    // Hold the pipeline while a memory op is detected or in flight; never during reset
    assign stall_M = reset & ((state == IDLE && is_mem) || state == BUSY);

    // Access sequencer: IDLE detects, BUSY waits for ack/timeout, DONE releases M
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
            ld_data    <= 32'h0;
            bus_err    <= 1'b0;
            ld_is_load <= 1'b0;
            ld_sgn     <= 1'b0;
            ld_size    <= SZ_W;
            ld_lane    <= 2'b00;
`ifdef ALIGN_EXC_EN
            addr_exc   <= 2'b00;
            exc_pc     <= 32'h0;
`endif
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
`ifdef ALIGN_EXC_EN
                    if (is_mem && misalign) begin
                        // trap without a bus cycle; exception visible in DONE
                        state    <= DONE;
                        addr_exc <= is_load ? 2'b01 : 2'b10;
                        exc_pc   <= pc_M;
                        ld_data  <= 32'h0;
                    end else
`endif
                    if (is_mem) begin
                        state      <= BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= is_store;
                        mem_addr   <= {ALUout_M[31:2], 2'b00};
                        mem_be     <= be_dec;
                        mem_wdata  <= wdata_dec;
                        ld_is_load <= is_load;
                        ld_sgn     <= sgn;
                        ld_size    <= size;
                        ld_lane    <= lane;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (ld_is_load)
                            ld_data <= extend(mem_rdata, ld_size, ld_sgn, ld_lane);
                        state <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // abandon the access; the result is defined as zero
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        ld_data <= 32'h0;
                        state   <= DONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
`ifdef ALIGN_EXC_EN
                    addr_exc <= 2'b00;
                    exc_pc   <= 32'h0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a main instance with a generous
// timeout, and a second instance with TIMEOUT_CYCLES=4 for the abort path.
module tb_mem_access_unit;

    localparam logic [5:0] OP_LW = 6'b100011, OP_LB = 6'b100000, OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH = 6'b100001, OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW = 6'b101011, OP_SH = 6'b101001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_M, pc_M, ALUout_M, RD2_M, mem_rdata;
    logic        mem_ack;
    logic        stall_M, mem_req, mem_we, bus_err;
    logic [31:0] mem_addr, mem_wdata, ld_data, exc_pc;
    logic [3:0]  mem_be;
    logic [1:0]  addr_exc;

    logic [31:0] instr2;
    logic        ack2;
    logic        stall2, req2, we2, berr2;
    logic [31:0] addr2, wdata2, ld2, epc2;
    logic [3:0]  be2;
    logic [1:0]  aexc2;

    int checks = 0;
    int errors = 0;

    int          st, rq;
    logic        c_we;
    logic [31:0] c_addr, c_wd;
    logic [3:0]  c_be;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Instr_M(Instr_M), .pc_M(pc_M),
        .ALUout_M(ALUout_M), .RD2_M(RD2_M), .stall_M(stall_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .ld_data(ld_data), .bus_err(bus_err),
        .addr_exc(addr_exc), .exc_pc(exc_pc));

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
        .clk(clk), .reset(reset), .Instr_M(instr2), .pc_M(pc_M),
        .ALUout_M(ALUout_M), .RD2_M(RD2_M), .stall_M(stall2),
        .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
        .mem_be(be2), .mem_wdata(wdata2), .mem_rdata(mem_rdata),
        .mem_ack(ack2), .ld_data(ld2), .bus_err(berr2),
        .addr_exc(aexc2), .exc_pc(epc2));

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h0};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start at posedge+1 with the FSM in IDLE; returns sampled in the DONE cycle
    task automatic access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd2,
                          input logic [31:0] rdata, input int ack_at,
                          output int stalls, output int reqs, output logic we,
                          output logic [31:0] a_o, output logic [3:0] be, output logic [31:0] wd);
        stalls = 0; reqs = 0; we = 1'bx; a_o = 'x; be = 'x; wd = 'x;
        Instr_M = mk(op); ALUout_M = addr; RD2_M = rd2; mem_ack = 1'b0; mem_rdata = 32'h0;
        #2;
        for (int i = 0; i < 40 && stall_M; i++) begin
            stalls++;
            if (mem_req) begin
                reqs++;
                if (reqs == 1) begin we = mem_we; a_o = mem_addr; be = mem_be; wd = mem_wdata; end
                if (reqs == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
            end
            tick;
            mem_ack = 1'b0; mem_rdata = 32'h0;
            #2;
        end
    endtask

    initial begin
        reset = 1'b1; Instr_M = 32'h0; pc_M = 32'h0; ALUout_M = 32'h0; RD2_M = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0; instr2 = 32'h0; ack2 = 1'b0;
        #1 reset = 1'b0;
        #2;
        chk("rst_req", mem_req, 0);    chk("rst_stall", stall_M, 0);
        chk("rst_ld", ld_data, 0);     chk("rst_berr", bus_err, 0);
        chk("rst_we", mem_we, 0);      chk("rst_addr", mem_addr, 0);
        chk("rst_be", mem_be, 0);      chk("rst_wdata", mem_wdata, 0);
        chk("rst_exc", addr_exc, 0);   chk("rst_excpc", exc_pc, 0);
        tick; tick;
        reset = 1'b1;

        // non-memory op: no stall, no request
        Instr_M = 32'h0000_0020; #2;
        chk("nop_stall", stall_M, 0);
        tick; #2;
        chk("nop_req", mem_req, 0); chk("nop_stall2", stall_M, 0);
        tick;

        // sw, ack in first BUSY cycle
        access(OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1, st, rq, c_we, c_addr, c_be, c_wd);
        chk("sw_stalls", st, 2); chk("sw_reqs", rq, 1); chk("sw_we", c_we, 1);
        chk("sw_addr", c_addr, 32'h100); chk("sw_be", c_be, 4'b1111);
        chk("sw_wdata", c_wd, 32'hDEADBEEF); chk("sw_done_req", mem_req, 0);
        tick;

        // lb at 0x203, ack in the 5th BUSY cycle
        access(OP_LB, 32'h203, 32'h0, 32'h80FF1234, 5, st, rq, c_we, c_addr, c_be, c_wd);
        chk("lb_stalls", st, 6); chk("lb_reqs", rq, 5); chk("lb_we", c_we, 0);
        chk("lb_addr", c_addr, 32'h200); chk("lb_be", c_be, 4'b1000);
        chk("lb_ld", ld_data, 32'hFFFFFF80);
        tick;
        access(OP_LBU, 32'h203, 32'h0, 32'h80FF1234, 5, st, rq, c_we, c_addr, c_be, c_wd);
        chk("lbu_stalls", st, 6); chk("lbu_ld", ld_data, 32'h00000080);
        tick;

        // sh then lhu back-to-back
        access(OP_SH, 32'h12, 32'h0000ABCD, 32'h0, 1, st, rq, c_we, c_addr, c_be, c_wd);
        chk("sh_stalls", st, 2); chk("sh_be", c_be, 4'b1100);
        chk("sh_wdata", c_wd, 32'hABCDABCD); chk("sh_addr", c_addr, 32'h10);
        tick;
        access(OP_LHU, 32'h12, 32'h0, 32'hABCD0000, 1, st, rq, c_we, c_addr, c_be, c_wd);
        chk("lhu_stalls", st, 2); chk("lhu_be", c_be, 4'b1100);
        chk("lhu_ld", ld_data, 32'h0000ABCD);
        tick;

        // lh low half, negative
        access(OP_LH, 32'h10, 32'h0, 32'h12348001, 2, st, rq, c_we, c_addr, c_be, c_wd);
        chk("lh_stalls", st, 3); chk("lh_be", c_be, 4'b0011);
        chk("lh_ld", ld_data, 32'hFFFF8001);
        tick;

        // stray ack in IDLE must not change the load result
        Instr_M = 32'h0; mem_ack = 1'b1; mem_rdata = 32'h55555555; #2;
        chk("stray_stall", stall_M, 0);
        tick; mem_ack = 1'b0; mem_rdata = 32'h0; #2;
        chk("stray_ld", ld_data, 32'hFFFF8001); chk("stray_req", mem_req, 0);
        tick;

        // reset in the second BUSY cycle, then re-issue
        Instr_M = mk(OP_LW); ALUout_M = 32'h40; #2;
        chk("rr_idle_stall", stall_M, 1);
        tick; #2;
        chk("rr_busy1_req", mem_req, 1);
        tick; #2;
        reset = 1'b0; #1;
        chk("rr_req", mem_req, 0); chk("rr_stall", stall_M, 0); chk("rr_ld", ld_data, 0);
        tick; tick;
        reset = 1'b1;
        access(OP_LW, 32'h40, 32'h0, 32'h11223344, 1, st, rq, c_we, c_addr, c_be, c_wd);
        chk("rr_stalls", st, 2); chk("rr_reqs", rq, 1);
        chk("rr_addr", c_addr, 32'h40); chk("rr_ld2", ld_data, 32'h11223344);
        tick;

        // misaligned lw at 0x101
        pc_M = 32'h0040_0ABC;
        access(OP_LW, 32'h101, 32'h0, 32'hCAFEF00D, 1, st, rq, c_we, c_addr, c_be, c_wd);
`ifdef ALIGN_EXC_EN
        chk("mis_stalls", st, 1); chk("mis_reqs", rq, 0);
        chk("mis_exc", addr_exc, 2'b01); chk("mis_pc", exc_pc, 32'h0040_0ABC);
        chk("mis_ld", ld_data, 0);
`else
        chk("mis_stalls", st, 2); chk("mis_reqs", rq, 1);
        chk("mis_addr", c_addr, 32'h100); chk("mis_be", c_be, 4'b1111);
        chk("mis_ld", ld_data, 32'hCAFEF00D); chk("mis_exc", addr_exc, 0);
`endif
        tick;
        Instr_M = 32'h0; #2;
        chk("mis_exc_clr", addr_exc, 0); chk("mis_stall_clr", stall_M, 0);
        tick;

        // timeout instance: one good load, then an unanswered one
        instr2 = mk(OP_LW); ALUout_M = 32'h80; #2;
        chk("to_idle_stall", stall2, 1);
        tick; ack2 = 1'b1; mem_rdata = 32'h600DF00D;
        tick; ack2 = 1'b0; mem_rdata = 32'h0; #2;
        chk("to_first_ld", ld2, 32'h600DF00D); chk("to_first_stall", stall2, 0);
        tick;
        st = 0; rq = 0; #2;
        for (int i = 0; i < 40 && stall2; i++) begin
            st++;
            if (req2) rq++;
            tick; #2;
        end
        chk("to_stalls", st, 5); chk("to_reqs", rq, 4);
        chk("to_berr", berr2, 1); chk("to_ld", ld2, 0); chk("to_req_drop", req2, 0);
        tick;
        instr2 = 32'h0; #2;
        chk("to_berr_clr", berr2, 0); chk("to_resume", stall2, 0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
